// File: rtl/riscv_defines.sv
// riscv_defines
// Shared decode constants for the custom string-operation instructions
// (OPCODE_STR_OPS). It also holds the byte-map constants and the FSM state
// type used by the string unit.
// No ports (package).
package riscv_defines;

  localparam logic [6:0] OPCODE_STR_OPS = 7'h0B;

  localparam int unsigned STR_OP_WIDTH = 2;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'b00;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'b01;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'b10;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'b11;

  // Replacement digits for the LEET mapping
  localparam logic [7:0] LEET_A = 8'h34;
  localparam logic [7:0] LEET_E = 8'h33;
  localparam logic [7:0] LEET_I = 8'h31;
  localparam logic [7:0] LEET_O = 8'h30;
  localparam logic [7:0] LEET_S = 8'h35;
  localparam logic [7:0] LEET_T = 8'h37;

  localparam logic [7:0] ROT13_OFFSET = 8'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } str_state_t;

endpackage

// File: rtl/riscv_str_byte_xform.sv
// riscv_str_byte_xform
// Purely combinational transform of one ASCII byte under the selected
// string operator.
// Ports:
//   op_i    in  STR_OP_WIDTH  operator (UPPER/LOWER/LEET/ROT13)
//   byte_i  in  8             source byte
//   byte_o  out 8             transformed byte
module riscv_str_byte_xform
  import riscv_defines::*;
(
  input  logic [STR_OP_WIDTH-1:0] op_i,
  input  logic [7:0]              byte_i,
  output logic [7:0]              byte_o
);

  logic isLower;
  logic isUpper;

  assign isLower = (byte_i >= 8'h61) && (byte_i <= 8'h7A);
  assign isUpper = (byte_i >= 8'h41) && (byte_i <= 8'h5A);

  always_comb begin
    byte_o = byte_i;
    // Bytes outside 7-bit ASCII are never touched
    if (!byte_i[7]) begin
      unique case (op_i)
        STR_OP_UPPER: if (isLower) byte_o = byte_i - 8'h20;
        STR_OP_LOWER: if (isUpper) byte_o = byte_i + 8'h20;
        STR_OP_ROT13: begin
          // First half of each case range moves forward, second half back,
          // which is rotation by 13 mod 26 without a modulo
          if (isLower) begin
            byte_o = (byte_i <= 8'h6D) ? byte_i + ROT13_OFFSET : byte_i - ROT13_OFFSET;
          end else if (isUpper) begin
            byte_o = (byte_i <= 8'h4D) ? byte_i + ROT13_OFFSET : byte_i - ROT13_OFFSET;
          end
        end
        STR_OP_LEET: begin
          unique case (byte_i)
            8'h61, 8'h41: byte_o = LEET_A;
            8'h65, 8'h45: byte_o = LEET_E;
            8'h69, 8'h49: byte_o = LEET_I;
            8'h6F, 8'h4F: byte_o = LEET_O;
            8'h73, 8'h53: byte_o = LEET_S;
            8'h74, 8'h54: byte_o = LEET_T;
            default:      byte_o = byte_i;
          endcase
        end
        default: byte_o = byte_i;
      endcase
    end
  end

endmodule

// File: rtl/riscv_str_ops_unit.sv
// riscv_str_ops_unit
// Multi-cycle EX-stage unit for the custom string instructions. It transforms
// the four packed ASCII bytes of rs1, BYTES_PER_CYCLE bytes per busy cycle,
// and hands the word to WB under a valid/ready handshake.
// Ports:
//   clk          in  1   core clock
//   rst          in  1   synchronous active-high reset
//   enable_i     in  1   decoder issues a string op this cycle
//   operator_i   in  2   string operator
//   operand_a_i  in  32  rs1 value, byte k = bits [8k+7:8k]
//   kill_i       in  1   pipeline flush, aborts current op
//   ex_ready_i   in  1   downstream accepts the result
//   ready_o      out 1   unit can accept enable_i this cycle
//   valid_o      out 1   result_o valid
//   result_o     out 32  transformed word
module riscv_str_ops_unit
  import riscv_defines::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_a_i,
  input  logic                    kill_i,
  input  logic                    ex_ready_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [31:0]             result_o
);

  localparam logic [2:0] STEP = 3'(BYTES_PER_CYCLE);
  // Counter value at the start of the chunk that contains byte 3
  localparam logic [2:0] LAST = 3'(4 - BYTES_PER_CYCLE);

  str_state_t              state_q, state_d;
  logic [STR_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             operand_q, operand_d;
  logic [31:0]             result_q, result_d;
  logic [2:0]              cnt_q, cnt_d;

  logic       accept;
  logic [1:0] chunkIdx [BYTES_PER_CYCLE];
  logic [7:0] xfIn     [BYTES_PER_CYCLE];
  logic [7:0] xfOut    [BYTES_PER_CYCLE];

  assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ex_ready_i);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

  // A flush wins over any new issue in the same cycle
  assign accept = enable_i && ready_o && !kill_i;

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_xform
    assign chunkIdx[g] = cnt_q[1:0] + 2'(g);
    assign xfIn[g]     = operand_q[{chunkIdx[g], 3'b000} +: 8];

    riscv_str_byte_xform u_xform (
      .op_i   (op_q),
      .byte_i (xfIn[g]),
      .byte_o (xfOut[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    result_d  = result_q;
    cnt_d     = cnt_q;

    if (kill_i) begin
      state_d = IDLE;
    end else if (accept) begin
      // Same latch from IDLE and from a completed DONE handshake; clearing
      // the result keeps unprocessed bytes at zero while busy
      state_d   = BUSY;
      op_d      = operator_i;
      operand_d = operand_a_i;
      result_d  = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        BUSY: begin
          for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            result_d[{chunkIdx[g], 3'b000} +: 8] = xfOut[g];
          end
          cnt_d = cnt_q + STEP;
          if (cnt_q == LAST) state_d = DONE;
        end
        DONE: if (ex_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= STR_OP_UPPER;
      operand_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_str_ops_unit.sv
// tb_riscv_str_ops_unit
// Self-checking bench for riscv_str_ops_unit. Three instances cover
// BYTES_PER_CYCLE = 1, 2 and 4; a vector table runs on each, followed by
// hand-written handshake, hold, kill and reset sequences.
module tb_riscv_str_ops_unit;
  import riscv_defines::*;

  logic        clk;
  logic        rst      [3];
  logic        enable   [3];
  logic [1:0]  opr      [3];
  logic [31:0] operandA [3];
  logic        kill     [3];
  logic        exReady  [3];
  logic        readyO   [3];
  logic        validO   [3];
  logic [31:0] resultO  [3];

  int bpcOf [3] = '{1, 2, 4};
  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  riscv_str_ops_unit #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst[0]), .enable_i(enable[0]), .operator_i(opr[0]),
    .operand_a_i(operandA[0]), .kill_i(kill[0]), .ex_ready_i(exReady[0]),
    .ready_o(readyO[0]), .valid_o(validO[0]), .result_o(resultO[0]));

  riscv_str_ops_unit #(.BYTES_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst[1]), .enable_i(enable[1]), .operator_i(opr[1]),
    .operand_a_i(operandA[1]), .kill_i(kill[1]), .ex_ready_i(exReady[1]),
    .ready_o(readyO[1]), .valid_o(validO[1]), .result_o(resultO[1]));

  riscv_str_ops_unit #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst[2]), .enable_i(enable[2]), .operator_i(opr[2]),
    .operand_a_i(operandA[2]), .kill_i(kill[2]), .ex_ready_i(exReady[2]),
    .ready_o(readyO[2]), .valid_o(validO[2]), .result_o(resultO[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents one op for a single cycle; the caller makes sure ready_o is high
  task automatic applyStimulus(input int d, input logic [1:0] op, input logic [31:0] a);
    enable[d]   = 1'b1;
    opr[d]      = op;
    operandA[d] = a;
    tick();
    enable[d]   = 1'b0;
  endtask

  task automatic waitValid(input int d, output int cycles);
    cycles = 0;
    while (!validO[d] && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!validO[d]) begin
      errorCount++;
      checkCount++;
      $display("[TB] FAIL timeout dut%0d: valid_o never rose within %0d cycles", d, cycles);
    end
  endtask

  initial begin
    int cyc;

    vecs[0] = '{STR_OP_UPPER, 32'h5A636261, 32'h5A434241};
    vecs[1] = '{STR_OP_LOWER, 32'h41424344, 32'h61626364};
    vecs[2] = '{STR_OP_ROT13, 32'h7A216948, 32'h6D217655};
    vecs[3] = '{STR_OP_LEET,  32'h74736574, 32'h37353337};
    vecs[4] = '{STR_OP_UPPER, 32'hFF7B402F, 32'hFF7B402F};
    vecs[5] = '{STR_OP_ROT13, 32'h5A4E4D41, 32'h4D415A4E};
    vecs[6] = '{STR_OP_LEET,  32'h4F49452F, 32'h3031332F};
    vecs[7] = '{STR_OP_LEET,  32'h62545341, 32'h62373534};
    vecs[8] = '{STR_OP_LOWER, 32'h80C15A40, 32'h80C17A40};
    vecs[9] = '{STR_OP_ROT13, 32'h6E6D4E4D, 32'h617A415A};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; enable[d] = 1'b0; opr[d] = '0; operandA[d] = '0;
      kill[d] = 1'b0; exReady[d] = 1'b1;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    #1;

    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset valid dut%0d", d), 32'(validO[d]), 32'd0);
      checkOutput($sformatf("reset ready dut%0d", d), 32'(readyO[d]), 32'd1);
      checkOutput($sformatf("reset result dut%0d", d), resultO[d], 32'd0);
    end

    $display("[TB] table vectors");
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 10; v++) begin
        applyStimulus(d, vecs[v].op, vecs[v].a);
        waitValid(d, cyc);
        checkOutput($sformatf("latency dut%0d vec%0d", d, v), 32'(cyc), 32'(4 / bpcOf[d]));
        checkOutput($sformatf("result dut%0d vec%0d", d, v), resultO[d], vecs[v].exp);
        checkOutput($sformatf("done ready dut%0d vec%0d", d, v), 32'(readyO[d]), 32'd1);
        tick();
        checkOutput($sformatf("idle valid dut%0d vec%0d", d, v), 32'(validO[d]), 32'd0);
      end
    end

    $display("[TB] back-to-back issue on DONE");
    applyStimulus(0, STR_OP_LOWER, 32'h41424344);
    waitValid(0, cyc);
    checkOutput("b2b first result", resultO[0], 32'h61626364);
    applyStimulus(0, STR_OP_ROT13, 32'h7A216948);
    checkOutput("b2b busy valid", 32'(validO[0]), 32'd0);
    checkOutput("b2b no idle bubble", 32'(readyO[0]), 32'd0);
    waitValid(0, cyc);
    checkOutput("b2b second latency", 32'(cyc), 32'd4);
    checkOutput("b2b second result", resultO[0], 32'h6D217655);
    tick();

    $display("[TB] result hold with ex_ready low");
    exReady[0] = 1'b0;
    applyStimulus(0, STR_OP_LEET, 32'h74736574);
    waitValid(0, cyc);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold result %0d", i), resultO[0], 32'h37353337);
      checkOutput($sformatf("hold valid %0d", i), 32'(validO[0]), 32'd1);
      checkOutput($sformatf("hold ready %0d", i), 32'(readyO[0]), 32'd0);
      tick();
    end
    exReady[0] = 1'b1;
    #1;
    checkOutput("hold release ready", 32'(readyO[0]), 32'd1);
    tick();
    checkOutput("hold release idle", 32'(validO[0]), 32'd0);

    $display("[TB] kill during BUSY");
    applyStimulus(0, STR_OP_UPPER, 32'h5A636261);
    tick();
    kill[0] = 1'b1; enable[0] = 1'b1;
    tick();
    kill[0] = 1'b0; enable[0] = 1'b0;
    checkOutput("kill busy valid", 32'(validO[0]), 32'd0);
    checkOutput("kill busy ready", 32'(readyO[0]), 32'd1);
    tick();
    checkOutput("kill busy stays idle", 32'(validO[0]), 32'd0);

    $display("[TB] kill overrides accept in DONE");
    applyStimulus(0, STR_OP_UPPER, 32'h5A636261);
    waitValid(0, cyc);
    kill[0] = 1'b1; enable[0] = 1'b1; opr[0] = STR_OP_LOWER; operandA[0] = 32'h41424344;
    tick();
    kill[0] = 1'b0; enable[0] = 1'b0;
    checkOutput("kill done valid", 32'(validO[0]), 32'd0);
    checkOutput("kill done not busy", 32'(readyO[0]), 32'd1);

    $display("[TB] reset during BUSY");
    applyStimulus(0, STR_OP_UPPER, 32'h5A636261);
    tick();
    checkOutput("partial result", resultO[0], 32'h00000041);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    #1;
    checkOutput("rst busy valid", 32'(validO[0]), 32'd0);
    checkOutput("rst busy result", resultO[0], 32'd0);
    checkOutput("rst busy ready", 32'(readyO[0]), 32'd1);

    applyStimulus(0, STR_OP_ROT13, 32'h5A4E4D41);
    waitValid(0, cyc);
    checkOutput("post rst latency", 32'(cyc), 32'd4);
    checkOutput("post rst result", resultO[0], 32'h4D415A4E);
    tick();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
